// File: rtl/tmds_link_sequencer.sv
// TMDS link bring-up sequencer: waits for a stable PLL lock, pulses the serializer reset,
// flushes control tokens, then forwards encoded symbols. Optional macro: TMDS_TEST_PATTERN_EN.
module tmds_link_sequencer #(
  parameter int LOCK_STABLE  = 64,
  parameter int RST_CYCLES   = 8,
  parameter int FLUSH_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        link_en,
`ifdef TMDS_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [29:0] tmds_in,
  output logic [29:0] tmds_out,
  output logic        serdes_rst,
  output logic        link_up,
  output logic [2:0]  state,
  output logic [7:0]  lock_loss_cnt
);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RST    = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_ACTIVE = 3'd4;

  localparam int MAX_A = (LOCK_STABLE > RST_CYCLES) ? LOCK_STABLE : RST_CYCLES;
  localparam int MAX_C = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

  localparam logic [29:0] CTRL_TOKENS = {3{10'b1101010100}};
  localparam logic [29:0] PAT_A       = {3{10'h155}};
  localparam logic [29:0] PAT_B       = {3{10'h2AA}};

  logic          lock_meta_r;
  logic          lock_s;
  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [7:0]    lock_loss_cnt_r;
  logic          lock_loss_evt_s;
  logic          serdes_rst_r;
  logic          serdes_rst_nxt_s;
  logic          link_up_r;
  logic          link_up_nxt_s;
  logic [29:0]   tmds_out_r;
  logic [29:0]   tmds_nxt_s;
  logic          pat_phase_r;
  logic          pat_phase_nxt_s;
  logic          test_mode_s;

`ifdef TMDS_TEST_PATTERN_EN
  assign test_mode_s = test_mode;
`else
  assign test_mode_s = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_r <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_s      <= lock_meta_r;
    end
  end

  // Next-state logic; disable outranks lock loss in every state.
  always_comb begin
    next_state_s = S_OFF;
    if (!link_en) begin
      next_state_s = S_OFF;
    end else begin
      case (state_r)
        S_OFF:    next_state_s = S_WAIT;
        S_WAIT:   next_state_s = (lock_s && (cnt_r == LOCK_LAST)) ? S_RST : S_WAIT;
        S_RST:    next_state_s = !lock_s ? S_WAIT : ((cnt_r == RST_LAST) ? S_FLUSH : S_RST);
        S_FLUSH:  next_state_s = !lock_s ? S_WAIT : ((cnt_r == FLUSH_LAST) ? S_ACTIVE : S_FLUSH);
        S_ACTIVE: next_state_s = !lock_s ? S_WAIT : S_ACTIVE;
        default:  next_state_s = S_OFF;
      endcase
    end
  end

  // Output and counter next values, derived from the upcoming state so registers change with it.
  always_comb begin
    cnt_nxt_s        = '0;
    serdes_rst_nxt_s = 1'b1;
    link_up_nxt_s    = 1'b0;
    tmds_nxt_s       = CTRL_TOKENS;
    pat_phase_nxt_s  = 1'b0;
    lock_loss_evt_s  = link_en && !lock_s &&
                       ((state_r == S_RST) || (state_r == S_FLUSH) || (state_r == S_ACTIVE));
    if (next_state_s != state_r) begin
      cnt_nxt_s = '0;
    end else begin
      case (state_r)
        S_WAIT:  cnt_nxt_s = lock_s ? (cnt_r + CW'(1)) : '0;
        S_RST:   cnt_nxt_s = cnt_r + CW'(1);
        S_FLUSH: cnt_nxt_s = cnt_r + CW'(1);
        default: cnt_nxt_s = '0;
      endcase
    end
    case (next_state_s)
      S_FLUSH: begin
        serdes_rst_nxt_s = 1'b0;
      end
      S_ACTIVE: begin
        serdes_rst_nxt_s = 1'b0;
        link_up_nxt_s    = 1'b1;
        if (test_mode_s && (state_r == S_ACTIVE)) begin
          tmds_nxt_s      = pat_phase_r ? PAT_B : PAT_A;
          pat_phase_nxt_s = ~pat_phase_r;
        end else begin
          tmds_nxt_s      = tmds_in;
          pat_phase_nxt_s = 1'b0;
        end
      end
      default: begin
        serdes_rst_nxt_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= S_OFF;
      cnt_r           <= '0;
      lock_loss_cnt_r <= 8'd0;
      serdes_rst_r    <= 1'b1;
      link_up_r       <= 1'b0;
      tmds_out_r      <= CTRL_TOKENS;
      pat_phase_r     <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= cnt_nxt_s;
      serdes_rst_r <= serdes_rst_nxt_s;
      link_up_r    <= link_up_nxt_s;
      tmds_out_r   <= tmds_nxt_s;
      pat_phase_r  <= pat_phase_nxt_s;
      if (lock_loss_evt_s && (lock_loss_cnt_r != 8'hFF)) begin
        lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
      end else begin
        lock_loss_cnt_r <= lock_loss_cnt_r;
      end
    end
  end

  assign state         = state_r;
  assign link_up       = link_up_r;
  assign serdes_rst    = serdes_rst_r;
  assign tmds_out      = tmds_out_r;
  assign lock_loss_cnt = lock_loss_cnt_r;

endmodule
